// File: rtl/gpio_in_irq.sv
// Per-pin input synchronizer, edge detector and sticky W1C interrupt status.
// Optional per-pin debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_in_irq #(
  parameter int length       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [length-1:0] gpio_in,
  input  logic [length-1:0] irq_en,
  input  logic [length-1:0] irq_rise,
  input  logic [length-1:0] irq_both,
  input  logic [length-1:0] irq_clear,
  output logic [length-1:0] gpio_sync,
  output logic [length-1:0] edge_pulse,
  output logic [length-1:0] irq_status,
  output logic              irq
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gpio_in_irq: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CNT < 1) begin : g_bad_deb
    $error("gpio_in_irq: DEBOUNCE_CNT must be at least 1");
  end

  logic [length-1:0] sync_q [SYNC_STAGES];
  logic [length-1:0] s;
  logic [length-1:0] filt;
  logic [length-1:0] prev;
  logic [length-1:0] rise;
  logic [length-1:0] fall;
  logic [length-1:0] ev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned j = 1; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
    end
  end

  always_comb s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  logic [CW-1:0] cnt [length];

  // A level is accepted only after DEBOUNCE_CNT consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt <= '0;
      for (int unsigned i = 0; i < length; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < length; i++) begin
        if (s[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CNT - 1)) begin
          filt[i] <= s[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  always_comb filt = s;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= '0;
    end else begin
      prev <= filt;
    end
  end

  always_comb begin
    rise = filt & ~prev;
    fall = ~filt & prev;
    ev   = (irq_both & (rise | fall)) | (~irq_both & ((irq_rise & rise) | (~irq_rise & fall)));
  end

  // Set has priority over a same-cycle W1C clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_status <= '0;
    end else begin
      irq_status <= (ev & irq_en) | (irq_status & ~irq_clear);
    end
  end

  always_comb begin
    gpio_sync  = filt;
    edge_pulse = ev;
    irq        = |irq_status;
  end

endmodule

// File: tb/tb_gpio_in_irq.sv
// Self-checking bench for gpio_in_irq: directed scenarios plus randomized
// traffic against a sample-history reference model (GPIO_DEBOUNCE_EN aware).
module tb_gpio_in_irq;
  localparam int L  = 4;
  localparam int SS = 2;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [L-1:0] gpio_in   = '0;
  logic [L-1:0] irq_en    = '0;
  logic [L-1:0] irq_rise  = '0;
  logic [L-1:0] irq_both  = '0;
  logic [L-1:0] irq_clear = '0;
  logic [L-1:0] gpio_sync;
  logic [L-1:0] edge_pulse;
  logic [L-1:0] irq_status;
  logic         irq;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [L-1:0] hist[$];
  logic [L-1:0] s_hist[$];
  logic [L-1:0] m_filt = '0;
  logic [L-1:0] m_prev = '0;
  logic [L-1:0] m_status = '0;

  gpio_in_irq #(.length(L), .SYNC_STAGES(SS), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .irq_en(irq_en), .irq_rise(irq_rise),
    .irq_both(irq_both), .irq_clear(irq_clear), .gpio_sync(gpio_sync),
    .edge_pulse(edge_pulse), .irq_status(irq_status), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [L-1:0] sel_ev(input logic [L-1:0] f, input logic [L-1:0] p,
                                           input logic [L-1:0] rs, input logic [L-1:0] bo);
    logic [L-1:0] r, fl;
    r  = f & ~p;
    fl = ~f & p;
    return (bo & (r | fl)) | (~bo & ((rs & r) | (~rs & fl)));
  endfunction

  // One clock edge; the model absorbs the inputs present at that edge.
  task automatic tick();
    logic [L-1:0] s_new;
    bit           all_diff;
    @(posedge clk);
    if (!rst) begin
      hist.delete();
      repeat (SS) hist.push_back('0);
      s_hist.delete();
      m_filt   = '0;
      m_prev   = '0;
      m_status = '0;
    end else begin
      m_status = (sel_ev(m_filt, m_prev, irq_rise, irq_both) & irq_en) | (m_status & ~irq_clear);
      m_prev   = m_filt;
`ifdef GPIO_DEBOUNCE_EN
      for (int i = 0; i < L; i++) begin
        all_diff = (s_hist.size() >= DB);
        for (int k = 0; k < DB && all_diff; k++) begin
          if (s_hist[s_hist.size() - 1 - k][i] == m_filt[i]) all_diff = 1'b0;
        end
        if (all_diff) m_filt[i] = ~m_filt[i];
      end
`else
      all_diff = 1'b0;
`endif
      hist.push_back(gpio_in);
      if (hist.size() > SS) void'(hist.pop_front());
    end
    s_new = hist[0];
`ifdef GPIO_DEBOUNCE_EN
    s_hist.push_back(s_new);
    if (s_hist.size() > DB + 2) void'(s_hist.pop_front());
`else
    m_filt = s_new;
`endif
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    gpio_in = '0;
    repeat (3) tick();
    checks++; if (gpio_sync !== '0) begin errors++; $display("FAIL reset_sync: got %b expected 0000", gpio_sync); end
    checks++; if (edge_pulse !== '0) begin errors++; $display("FAIL reset_pulse: got %b expected 0000", edge_pulse); end
    checks++; if (irq_status !== '0) begin errors++; $display("FAIL reset_status: got %b expected 0000", irq_status); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst = 1'b1;
    tick();
  endtask

`ifndef GPIO_DEBOUNCE_EN
  task automatic test_rise();
    irq_en = 4'b0001; irq_rise = 4'b0001; irq_both = '0;
    tick();
    gpio_in = 4'b0001;
    tick();
    checks++; if (gpio_sync !== 4'b0000) begin errors++; $display("FAIL rise_sync_k: got %b expected 0000", gpio_sync); end
    tick();
    checks++; if (gpio_sync !== 4'b0001) begin errors++; $display("FAIL rise_sync_k1: got %b expected 0001", gpio_sync); end
    checks++; if (edge_pulse !== 4'b0001) begin errors++; $display("FAIL rise_pulse: got %b expected 0001", edge_pulse); end
    checks++; if (irq_status !== 4'b0000) begin errors++; $display("FAIL rise_status_early: got %b expected 0000", irq_status); end
    tick();
    checks++; if (edge_pulse !== 4'b0000) begin errors++; $display("FAIL rise_pulse_end: got %b expected 0000", edge_pulse); end
    checks++; if (irq_status !== 4'b0001) begin errors++; $display("FAIL rise_status: got %b expected 0001", irq_status); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b expected 1", irq); end
  endtask

  task automatic test_fall_both();
    irq_clear = 4'b0001;
    tick();
    irq_clear = '0;
    irq_en = 4'b0110; irq_rise = '0; irq_both = 4'b0100;
    gpio_in = 4'b0111;
    repeat (SS + 1) tick();
    checks++; if (irq_status !== 4'b0100) begin errors++; $display("FAIL fb_after_rise: got %b expected 0100", irq_status); end
    gpio_in = 4'b0001;
    repeat (SS + 1) tick();
    checks++; if (irq_status !== 4'b0110) begin errors++; $display("FAIL fb_after_fall: got %b expected 0110", irq_status); end
  endtask

  task automatic test_mask_w1c();
    irq_en = '0; irq_rise = 4'b1000;
    gpio_in = 4'b1001;
    repeat (SS) tick();
    checks++; if (edge_pulse !== 4'b1000) begin errors++; $display("FAIL mask_pulse: got %b expected 1000", edge_pulse); end
    tick();
    checks++; if (irq_status !== 4'b0110) begin errors++; $display("FAIL mask_status: got %b expected 0110", irq_status); end
    gpio_in = 4'b0001;
    repeat (SS + 1) tick();
    irq_clear = 4'b0010;
    tick();
    irq_clear = '0;
    checks++; if (irq_status !== 4'b0100) begin errors++; $display("FAIL w1c_status: got %b expected 0100", irq_status); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq: got %b expected 1", irq); end
  endtask

  task automatic test_collision();
    irq_en = 4'b0001; irq_rise = 4'b0001; irq_both = '0;
    gpio_in = 4'b0000;
    repeat (SS + 1) tick();
    gpio_in = 4'b0001;
    repeat (SS) tick();
    irq_clear = 4'b0001;
    tick();
    irq_clear = '0;
    checks++; if (irq_status !== 4'b0101) begin errors++; $display("FAIL collision: got %b expected 0101", irq_status); end
  endtask

  task automatic test_mid_reset();
    irq_en = 4'b1111; irq_both = 4'b1111;
    gpio_in = 4'b1111;
    repeat (SS + 1) tick();
    checks++; if (irq_status !== 4'b1111) begin errors++; $display("FAIL mr_full: got %b expected 1111", irq_status); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if ({gpio_sync, edge_pulse, irq_status, irq} !== '0) begin
      errors++; $display("FAIL mr_zero: got %b %b %b %b expected all 0", gpio_sync, edge_pulse, irq_status, irq);
    end
    repeat (SS) tick();
    checks++; if (irq_status !== 4'b0000) begin errors++; $display("FAIL mr_early: got %b expected 0000", irq_status); end
    tick();
    checks++; if (irq_status !== 4'b1111) begin errors++; $display("FAIL mr_fresh: got %b expected 1111", irq_status); end
    irq_clear = 4'b1111;
    tick();
    irq_clear = '0;
  endtask
`endif

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    rst = 1'b0; gpio_in = '0;
    tick();
    rst = 1'b1;
    irq_en = 4'b0001; irq_rise = 4'b0001; irq_both = '0;
    repeat (DB + 2) tick();
    gpio_in = 4'b0001;
    repeat (3) tick();
    gpio_in = 4'b0000;
    for (int c = 0; c < DB + SS + 3; c++) begin
      checks++; if (edge_pulse !== 4'b0000) begin errors++; $display("FAIL deb_glitch_pulse: got %b expected 0000", edge_pulse); end
      tick();
    end
    checks++; if (irq_status !== 4'b0000) begin errors++; $display("FAIL deb_glitch_status: got %b expected 0000", irq_status); end
    gpio_in = 4'b0001;
    repeat (SS) tick();
    repeat (DB - 1) tick();
    checks++; if (gpio_sync[0] !== 1'b0) begin errors++; $display("FAIL deb_early: got %b expected 0", gpio_sync[0]); end
    tick();
    checks++; if (gpio_sync[0] !== 1'b1) begin errors++; $display("FAIL deb_accept: got %b expected 1", gpio_sync[0]); end
    checks++; if (edge_pulse !== 4'b0001) begin errors++; $display("FAIL deb_pulse: got %b expected 0001", edge_pulse); end
  endtask
`endif

  task automatic test_random();
    logic [L-1:0] flip;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(149) != 0);
`ifdef GPIO_DEBOUNCE_EN
      flip = '0;
      for (int i = 0; i < L; i++) flip[i] = ($urandom_range(5) == 0);
      gpio_in = gpio_in ^ flip;
`else
      flip = L'($urandom);
      if ($urandom_range(1) == 0) gpio_in = flip;
`endif
      irq_en    = L'($urandom);
      irq_rise  = L'($urandom);
      irq_both  = L'($urandom);
      irq_clear = L'($urandom) & L'($urandom);
      #1;
      checks++; if (gpio_sync !== m_filt) begin errors++; $display("FAIL rnd_sync c=%0d: got %b expected %b", c, gpio_sync, m_filt); end
      checks++; if (edge_pulse !== sel_ev(m_filt, m_prev, irq_rise, irq_both)) begin
        errors++; $display("FAIL rnd_pulse c=%0d: got %b expected %b", c, edge_pulse, sel_ev(m_filt, m_prev, irq_rise, irq_both));
      end
      checks++; if (irq_status !== m_status) begin errors++; $display("FAIL rnd_status c=%0d: got %b expected %b", c, irq_status, m_status); end
      checks++; if (irq !== (|m_status)) begin errors++; $display("FAIL rnd_irq c=%0d: got %b expected %b", c, irq, |m_status); end
      tick();
    end
    rst = 1'b1;
    irq_clear = '0;
  endtask

  initial begin
    test_reset();
`ifndef GPIO_DEBOUNCE_EN
    test_rise();
    test_fall_both();
    test_mask_w1c();
    test_collision();
    test_mid_reset();
`else
    test_debounce();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
